// File: rtl/axi_sram_slave.sv
`default_nettype none
// axi_sram_slave: AXI3-style INCR/FIXED burst slave over a read-first single-clock SRAM.
// Define AXI_SRAM_RANGE_CHK_EN to return SLVERR for beats outside the mapped window.
module axi_sram_slave #(
   parameter int                ID_W      = 2,
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ID_W-1:0]     S_AXI_AWID,
   input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
   input  logic [3:0]          S_AXI_AWLEN,
   input  logic [2:0]          S_AXI_AWSIZE,
   input  logic [1:0]          S_AXI_AWBURST,
   input  logic                S_AXI_AWVALID,
   output logic                S_AXI_AWREADY,
   input  logic [DATA_W-1:0]   S_AXI_WDATA,
   input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
   input  logic                S_AXI_WLAST,
   input  logic                S_AXI_WVALID,
   output logic                S_AXI_WREADY,
   output logic [ID_W-1:0]     S_AXI_BID,
   output logic [1:0]          S_AXI_BRESP,
   output logic                S_AXI_BVALID,
   input  logic                S_AXI_BREADY,
   input  logic [ID_W-1:0]     S_AXI_ARID,
   input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
   input  logic [3:0]          S_AXI_ARLEN,
   input  logic [2:0]          S_AXI_ARSIZE,
   input  logic [1:0]          S_AXI_ARBURST,
   input  logic                S_AXI_ARVALID,
   output logic                S_AXI_ARREADY,
   output logic [ID_W-1:0]     S_AXI_RID,
   output logic [DATA_W-1:0]   S_AXI_RDATA,
   output logic [1:0]          S_AXI_RRESP,
   output logic                S_AXI_RLAST,
   output logic                S_AXI_RVALID,
   input  logic                S_AXI_RREADY
);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
   typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} rstate_t;

   // FIXED holds the address; every other burst code steps by the transfer size.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0] size,
                                                   input logic [1:0] burst);
      return (burst == 2'b00) ? a : a + (ADDR_W'(1) << size);
   endfunction

   logic [DATA_W-1:0] mem [DEPTH];

   wstate_t           w_state, w_next;
   logic              aw_ready, w_err, w_ok, aw_hs, w_hs, b_hs, w_last_beat;
   logic [ID_W-1:0]   w_id;
   logic [ADDR_W-1:0] w_addr, w_off;
   logic [3:0]        w_len, w_cnt;
   logic [2:0]        w_size;
   logic [1:0]        w_burst;

   rstate_t           r_state, r_next;
   logic              ar_ready, r_ok, ar_hs, r_hs, r_last_beat, r_fetch;
   logic [ID_W-1:0]   r_id;
   logic [ADDR_W-1:0] r_addr, r_fetch_addr, r_off;
   logic [3:0]        r_len, r_cnt;
   logic [2:0]        r_size;
   logic [1:0]        r_burst;
   logic [DATA_W-1:0] r_data;
   logic [1:0]        r_resp;

   assign aw_hs        = S_AXI_AWVALID && aw_ready;
   assign w_hs         = S_AXI_WVALID && (w_state == W_DATA);
   assign b_hs         = S_AXI_BREADY && (w_state == W_RESP);
   assign w_last_beat  = (w_cnt == w_len);
   assign w_off        = w_addr - BASE_ADDR;

   assign ar_hs        = S_AXI_ARVALID && ar_ready;
   assign r_hs         = S_AXI_RREADY && (r_state == R_DATA);
   assign r_last_beat  = (r_cnt == r_len);
   assign r_fetch_addr = (r_state == R_FETCH) ? r_addr : next_addr(r_addr, r_size, r_burst);
   assign r_fetch      = (r_state == R_FETCH) || (r_hs && !r_last_beat);
   assign r_off        = r_fetch_addr - BASE_ADDR;

`ifdef AXI_SRAM_RANGE_CHK_EN
   assign w_ok = {1'b0, w_off} < (ADDR_W+1)'(4 * DEPTH);
   assign r_ok = {1'b0, r_off} < (ADDR_W+1)'(4 * DEPTH);
`else
   assign w_ok = 1'b1;
   assign r_ok = 1'b1;
`endif

   // WLAST is not used for termination and the offsets are only partly decoded.
   logic unused_ok;
   assign unused_ok = &{1'b0, S_AXI_WLAST, w_off, r_off};

   always_comb begin
      w_next       = w_state;
      S_AXI_WREADY = 1'b0;
      S_AXI_BVALID = 1'b0;
      case (w_state)
         W_IDLE: if (aw_hs) w_next = W_DATA;
         W_DATA: begin
            S_AXI_WREADY = 1'b1;
            if (w_hs && w_last_beat) w_next = W_RESP;
         end
         W_RESP: begin
            S_AXI_BVALID = 1'b1;
            if (b_hs) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state  <= W_IDLE;
         aw_ready <= 1'b0;
         w_id     <= '0;
         w_addr   <= '0;
         w_len    <= '0;
         w_cnt    <= '0;
         w_size   <= '0;
         w_burst  <= '0;
         w_err    <= 1'b0;
      end else begin
         w_state  <= w_next;
         aw_ready <= (w_next == W_IDLE);
         if (aw_hs) begin
            w_id    <= S_AXI_AWID;
            w_addr  <= S_AXI_AWADDR;
            w_len   <= S_AXI_AWLEN;
            w_size  <= S_AXI_AWSIZE;
            w_burst <= S_AXI_AWBURST;
            w_cnt   <= '0;
            w_err   <= 1'b0;
         end
         if (w_hs) begin
            w_cnt  <= w_cnt + 4'd1;
            w_addr <= next_addr(w_addr, w_size, w_burst);
            if (!w_ok) w_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && w_hs && w_ok) begin
         for (int b = 0; b < STRB_W; b++)
            if (S_AXI_WSTRB[b]) mem[w_off[2 +: IDX_W]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_FETCH;
         R_FETCH: r_next = R_DATA;
         R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // Memory is read on the fetch edge and on every non-final beat, so the next word is
   // already registered when RREADY stays high; same-edge writes are not yet visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= R_IDLE;
         ar_ready <= 1'b0;
         r_id     <= '0;
         r_addr   <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_size   <= '0;
         r_burst  <= '0;
         r_data   <= '0;
         r_resp   <= 2'b00;
      end else begin
         r_state  <= r_next;
         ar_ready <= (r_next == R_IDLE);
         if (ar_hs) begin
            r_id    <= S_AXI_ARID;
            r_addr  <= S_AXI_ARADDR;
            r_len   <= S_AXI_ARLEN;
            r_size  <= S_AXI_ARSIZE;
            r_burst <= S_AXI_ARBURST;
            r_cnt   <= '0;
         end
         if (r_fetch) begin
            r_addr <= r_fetch_addr;
            r_data <= r_ok ? mem[r_off[2 +: IDX_W]] : '0;
            r_resp <= r_ok ? 2'b00 : 2'b10;
         end
         if (r_hs) r_cnt <= r_cnt + 4'd1;
      end
   end

   assign S_AXI_AWREADY = aw_ready;
   assign S_AXI_BID     = w_id;
   assign S_AXI_BRESP   = {w_err, 1'b0};
   assign S_AXI_ARREADY = ar_ready;
   assign S_AXI_RID     = r_id;
   assign S_AXI_RDATA   = r_data;
   assign S_AXI_RRESP   = r_resp;
   assign S_AXI_RVALID  = (r_state == R_DATA);
   assign S_AXI_RLAST   = (r_state == R_DATA) && r_last_beat;
endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// tb_axi_sram_slave: randomized self-checking bench for axi_sram_slave against a word-array model.
module tb_axi_sram_slave;
   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  awid = '0, arid = '0, bid, rid, bresp, rresp;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
   logic [3:0]  awlen = '0, arlen = '0, wstrb = '0;
   logic [2:0]  awsize = '0, arsize = '0;
   logic [1:0]  awburst = '0, arburst = '0;
   logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
   logic        arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rlast, rvalid;

   always #5 clk = ~clk;

   axi_sram_slave #(.ID_W(2), .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst(rst),
      .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
      .S_AXI_AWBURST(awburst), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WVALID(wvalid),
      .S_AXI_WREADY(wready), .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
      .S_AXI_BREADY(bready), .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
      .S_AXI_ARSIZE(arsize), .S_AXI_ARBURST(arburst), .S_AXI_ARVALID(arvalid),
      .S_AXI_ARREADY(arready), .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
      .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
   );

   logic [31:0] model [DEPTH];
   logic [31:0] wr_data[$];
   logic [3:0]  wr_strb[$];
   logic [31:0] got_data[$];
   logic [1:0]  got_resp[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Address of beat i computed directly from the burst start.
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i,
                                             input logic [2:0] size, input logic [1:0] burst);
      if (burst == 2'b00) return start;
      return start + 32'(i) * (32'd1 << size);
   endfunction

   function automatic bit in_range(input logic [31:0] a);
      bit chk = 1'b0;
`ifdef AXI_SRAM_RANGE_CHK_EN
      chk = 1'b1;
`endif
      return !chk || (a < 32'(4 * DEPTH));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   // Called at #1 after a rising edge; returns at the same phase.
   task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [1:0] id, input bit gaps);
      int n;
      bit err = 1'b0;
      logic [31:0] a;
      awid = id; awaddr = addr; awlen = 4'(len); awsize = size; awburst = burst; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 100) begin @(posedge clk); #1; n++; end
      check("aw_wait", n < 100, 1'b1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = (i == len); wvalid = 1'b1;
         n = 0;
         while (!wready && n < 100) begin @(posedge clk); #1; n++; end
         check("w_wait", n < 100, 1'b1);
         @(posedge clk);
         a = beat_addr(addr, i, size, burst);
         if (in_range(a)) begin
            for (int b = 0; b < 4; b++)
               if (wr_strb[i][b]) model[widx(a)][8*b +: 8] = wr_data[i][8*b +: 8];
         end else err = 1'b1;
         #1;
         wvalid = 1'b0; wlast = 1'b0;
      end
      n = 0;
      while (!bvalid && n < 100) begin @(posedge clk); #1; n++; end
      check("b_wait", n < 100, 1'b1);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; check("bvalid_hold", bvalid, 1'b1); end
      check("bid", bid, id);
      check("bresp", bresp, err ? 2'b10 : 2'b00);
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      check("bvalid_drop", bvalid, 1'b0);
      check("awready_back", awready, 1'b1);
   endtask

   // mode 0: RREADY always high, 1: toggling, 2: random.
   task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [1:0] id, input int mode);
      logic [31:0] exp_d[16];
      logic [1:0]  exp_r[16];
      logic [31:0] pd, a;
      logic [1:0]  pr;
      logic        pl;
      int n, beat;
      bit stalled;
      got_data.delete(); got_resp.delete();
      arid = id; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 100) begin @(posedge clk); #1; n++; end
      check("ar_wait", n < 100, 1'b1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         a = beat_addr(addr, i, size, burst);
         exp_d[i] = in_range(a) ? model[widx(a)] : 32'h0;
         exp_r[i] = in_range(a) ? 2'b00 : 2'b10;
      end
      check("rvalid_t1", rvalid, 1'b0);
      @(posedge clk); #1;
      check("rvalid_t2", rvalid, 1'b1);
      beat = 0; stalled = 1'b0; n = 0; pd = '0; pr = '0; pl = 1'b0;
      while (beat <= len && n < 200) begin
         case (mode)
            0:       rready = 1'b1;
            1:       rready = (n % 2 == 0);
            default: rready = 1'($urandom_range(0, 1));
         endcase
         check("rvalid_held", rvalid, 1'b1);
         if (rvalid) begin
            if (stalled) begin
               check("rdata_stable", rdata, pd);
               check("rlast_stable", rlast, pl);
               check("rresp_stable", rresp, pr);
            end
            if (rready) begin
               check("rdata", rdata, exp_d[beat]);
               check("rresp", rresp, exp_r[beat]);
               check("rlast", rlast, beat == len);
               check("rid", rid, id);
               got_data.push_back(rdata);
               got_resp.push_back(rresp);
               beat++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1; pd = rdata; pl = rlast; pr = rresp;
            end
         end
         @(posedge clk); #1;
         n++;
      end
      rready = 1'b0;
      check("r_beats", beat, len + 1);
      check("rvalid_after", rvalid, 1'b0);
      check("arready_back", arready, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] t2_exp[4];
      logic [31:0] addr;
      int len;
      t2_exp = '{32'h1, 32'h2, 32'hFFFF0003, 32'h4};

      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", awready, 1'b0);
      check("rst_arready", arready, 1'b0);
      check("rst_wready", wready, 1'b0);
      check("rst_bvalid", bvalid, 1'b0);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_rlast", rlast, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_bresp", bresp, 2'b00);
      rst = 1'b0;
      check("awready_first", awready, 1'b0);
      @(posedge clk); #1;
      check("awready_up", awready, 1'b1);
      check("arready_up", arready, 1'b1);

      // single-beat write then read
      wr_data = '{32'hDEADBEEF}; wr_strb = '{4'hF};
      axi_write(32'h10, 0, 3'd2, 2'b01, 2'd1, 1'b0);
      axi_read(32'h10, 0, 3'd2, 2'b01, 2'd1, 0);
      check("t1_rdata", got_data[0], 32'hDEADBEEF);

      // INCR burst with partial strobe merging into prior contents
      wr_data = '{32'hFFFFFFFF}; wr_strb = '{4'hF};
      axi_write(32'h28, 0, 3'd2, 2'b01, 2'd0, 1'b0);
      wr_data = '{32'h1, 32'h2, 32'h3, 32'h4}; wr_strb = '{4'hF, 4'hF, 4'h3, 4'hF};
      axi_write(32'h20, 3, 3'd2, 2'b01, 2'd2, 1'b0);
      axi_read(32'h20, 3, 3'd2, 2'b01, 2'd2, 0);
      for (int i = 0; i < 4; i++) check("t2_rdata", got_data[i], t2_exp[i]);

      // fill a window for stalled and random traffic
      for (int k = 0; k < 11; k++) begin
         wr_data.delete(); wr_strb.delete();
         for (int i = 0; i < 16; i++) begin
            wr_data.push_back($urandom); wr_strb.push_back(4'hF);
         end
         axi_write(32'h400 + 32'(k * 64), 15, 3'd2, 2'b01, 2'(k), 1'b1);
      end

      axi_read(32'h400, 7, 3'd2, 2'b01, 2'd3, 1);

      // AW and AR accepted together on the same word
      wr_data = '{32'h55}; wr_strb = '{4'hF};
      axi_write(32'h40, 0, 3'd2, 2'b01, 2'd0, 1'b0);
      wr_data = '{32'hAA}; wr_strb = '{4'hF};
      fork
         axi_write(32'h40, 0, 3'd2, 2'b01, 2'd3, 1'b0);
         axi_read(32'h40, 0, 3'd2, 2'b01, 2'd1, 0);
      join
      check("t4_old", got_data[0], 32'h55);
      axi_read(32'h40, 0, 3'd2, 2'b01, 2'd1, 0);
      check("t4_new", got_data[0], 32'hAA);

      // randomized bursts inside the filled window
      for (int t = 0; t < 40; t++) begin
         addr = 32'h400 + 32'($urandom_range(0, 160) * 4);
         len  = $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) begin
            wr_data.delete(); wr_strb.delete();
            for (int i = 0; i <= len; i++) begin
               wr_data.push_back($urandom); wr_strb.push_back(4'($urandom_range(0, 15)));
            end
            axi_write(addr, len, 3'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 1'b1);
         end else begin
            axi_read(addr, len, 3'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), 2);
         end
      end

      // top of the mapped window: SLVERR when checked, aliasing to word 0 otherwise
      wr_data = '{32'h0BAD0001, 32'h0BAD0002}; wr_strb = '{4'hF, 4'hF};
      axi_write(32'h0, 1, 3'd2, 2'b01, 2'd0, 1'b0);
      axi_read(32'h1000, 1, 3'd2, 2'b01, 2'd2, 0);
`ifdef AXI_SRAM_RANGE_CHK_EN
      check("t5_rresp0", got_resp[0], 2'b10);
      check("t5_rdata1", got_data[1], 32'h0);
`else
      check("t5_alias0", got_data[0], 32'h0BAD0001);
      check("t5_rresp1", got_resp[1], 2'b00);
`endif
      wr_data = '{32'h12345678, 32'h9ABCDEF0}; wr_strb = '{4'hF, 4'hF};
      axi_write(32'h1000, 1, 3'd2, 2'b01, 2'd1, 1'b0);
      axi_read(32'h0, 1, 3'd2, 2'b01, 2'd1, 0);

      // reset in the middle of a write burst
      awid = 2'd2; awaddr = 32'h900; awlen = 4'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
      @(posedge clk); #1;
      awvalid = 1'b0;
      check("t6_wready", wready, 1'b1);
      for (int i = 0; i < 2; i++) begin
         wdata = 32'hC0DE0000 + 32'(i); wstrb = 4'hF; wvalid = 1'b1;
         @(posedge clk);
         model[widx(32'h900 + 32'(4 * i))] = 32'hC0DE0000 + 32'(i);
         #1;
      end
      wvalid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check("t6_rst_bvalid", bvalid, 1'b0);
      check("t6_rst_awready", awready, 1'b0);
      check("t6_rst_wready", wready, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("t6_awready", awready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("t6_no_bvalid", bvalid, 1'b0);
         @(posedge clk); #1;
      end
      axi_read(32'h900, 1, 3'd2, 2'b01, 2'd0, 0);
      axi_read(32'h400, 3, 3'd2, 2'b01, 2'd0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
